avalanche_sweep_ctrl: RTL
=========================

// Module: avalanche_sweep_ctrl
// PURPOSE
//  Hardware avalanche-effect engine for the encode+encrypt datapath. Runs the attached core once on
//  base_i (baseline), then once per input bit with that bit flipped; emits XOR-vs-baseline and
//  Hamming weight per run, plus running sum/min/max. Sits between a host/stimulus block and any
//  start/ready core (e.g. top_encode_encrypt), replacing the per-bit sweep done by hand in simulation.
// PARAMETERS
//  IN_W      16    width of core input word (number of bits swept)
//  OUT_W     64    width of core output word
//  CNT_W     7     popcount width, = $clog2(OUT_W+1)
//  SUM_W     11    accumulated-weight width, = CNT_W+$clog2(IN_W)
//  TIMEOUT   4096  max cycles waiting for core_ready_i per run before error abort
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      asynchronous, active-low reset
//  start_i      in   1      begin sweep (sampled in IDLE/DONE only)
//  base_i       in   IN_W   base input word, captured on accepted start_i
//  busy_o       out  1      sweep in progress
//  done_o       out  1      sweep finished (level, cleared by next accepted start)
//  err_o        out  1      sweep aborted by timeout (level, cleared by next accepted start)
//  core_clr_o   out  1      one-cycle clear pulse to core before each run
//  core_start_o out  1      one-cycle launch pulse to core
//  core_data_o  out  IN_W   word presented to core, stable from CLR until next CLR
//  core_ready_i in   1      core result valid (level)
//  core_data_i  in   OUT_W  core result
//  res_valid_o  out  1      per-bit result valid
//  res_ready_i  in   1      per-bit result accepted when valid&ready
//  res_bit_o    out  $clog2(IN_W)  index of flipped bit
//  res_xor_o    out  OUT_W  core_data_i XOR baseline
//  res_cnt_o    out  CNT_W  popcount(res_xor_o)
//  sum_o/min_o/max_o out SUM_W/CNT_W/CNT_W  statistics over emitted results
// BEHAVIOUR
//  Reset: all outputs 0 except min_o=OUT_W; FSM->IDLE; run index 0; internal baseline 0.
//  FSM: IDLE -start_i-> CLR -> LAUNCH -> WAIT -ready-> COUNT -> (run0: CLR) / (run>0: EMIT);
//   EMIT -accept-> CLR if more bits else DONE; WAIT -timeout-> DONE with err_o=1.
//  Accepted start (IDLE or DONE): capture base_i, clear sum_o=0,min_o=OUT_W,max_o=0,done_o,err_o.
//  start_i in any other state ignored; base_i changes after capture ignored.
//  Run r=0: core_data_o=base; runs r=1..IN_W: core_data_o=base ^ (1<<(r-1)).
//  CLR: core_clr_o=1 one cycle. LAUNCH: core_start_o=1 one cycle.
//  WAIT: core_ready_i ignored in the first WAIT cycle (stale level from core); counter from 0,
//   timeout when count reaches TIMEOUT-1 without ready.
//  COUNT: register core_data_i (run0 -> baseline only, nothing emitted); else res_xor_o, res_cnt_o,
//   res_bit_o=r-1. Popcount is registered, one cycle.
//  EMIT: res_valid_o=1; res_* held stable until res_ready_i; on acceptance sum+=cnt, min/max update
//   in same edge, res_valid_o drops next cycle (no back-to-back results; min spacing = 1 full run).
//  busy_o=1 in every state except IDLE/DONE. done_o set on entry to DONE (also on timeout).
//  Latency per run: 4 cycles + core latency + EMIT wait. Results strictly ordered bit 0..IN_W-1.
//  Reset mid-sweep: immediate async return to reset values; partial stats discarded; core pulses 0.
//  sum_o never wraps: SUM_W sized for IN_W*OUT_W.
// TESTING
//  1 Stub core out={48'h0,in}, 4-cycle latency, base 16'h245A -> 16 results, res_xor_o=1<<i,
//    res_cnt_o=1, res_bit_o=i; done_o=1, sum_o=16, min_o=max_o=1, err_o=0.
//  2 Same stub, res_ready_i low 10 cycles on bit 3 -> res_* stable throughout, no skipped/duplicate
//    index, final sum_o=16.
//  3 Core never asserts ready, TIMEOUT=100 -> err_o=1, done_o=1 after 100 WAIT cycles, no res_valid_o.
//  4 Drop rst during bit 7 run -> all outputs at reset values same cycle; new start completes
//    clean sweep with sum_o=16.
//  5 Real encode+encrypt core, key 64'h0123456789abcdef, base 16'h245A -> res_xor_o/res_cnt_o match
//    software model bit-for-bit; sum_o equals sum of model counts.
//  6 Pulse start_i with base 16'hFFFF mid-sweep -> ignored; results still from 16'h245A.

Source files
------------

// File: rtl/avalanche_sweep_ctrl.sv
// avalanche_sweep_ctrl
// Drives a start/ready core once on a base word (the baseline) and then once for
// every input bit with that bit flipped. For each flipped run it reports the XOR
// against the baseline, the popcount of that XOR, and keeps running sum/min/max
// statistics of the popcounts for the whole sweep.
module avalanche_sweep_ctrl #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 64,
  parameter int CNT_W   = $clog2(OUT_W + 1),
  parameter int SUM_W   = CNT_W + $clog2(IN_W),
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [IN_W-1:0]          base_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     core_clr_o,
  output logic                     core_start_o,
  output logic [IN_W-1:0]          core_data_o,
  input  logic                     core_ready_i,
  input  logic [OUT_W-1:0]         core_data_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [$clog2(IN_W)-1:0]  res_bit_o,
  output logic [OUT_W-1:0]         res_xor_o,
  output logic [CNT_W-1:0]         res_cnt_o,
  output logic [SUM_W-1:0]         sum_o,
  output logic [CNT_W-1:0]         min_o,
  output logic [CNT_W-1:0]         max_o
);

  localparam int BIT_W = $clog2(IN_W);
  localparam int RUN_W = $clog2(IN_W + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OUT_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_COUNT  = 3'd4,
    S_EMIT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             state;
  logic [RUN_W-1:0]   run_q;       // 0 = baseline run, r>0 = bit r-1 flipped
  logic [IN_W-1:0]    base_q;
  logic [OUT_W-1:0]   baseline_q;
  logic [TMO_W-1:0]   wait_cnt;

  logic [OUT_W-1:0]   xor_p0;

  // Number of ones in a core result difference.
  function automatic logic [CNT_W-1:0] popcount(input logic [OUT_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < OUT_W; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Core input for run r: the base itself for r=0, otherwise bit r-1 flipped.
  function automatic logic [IN_W-1:0] run_word(input logic [IN_W-1:0] b,
                                               input logic [RUN_W-1:0] r);
    if (r == '0) return b;
    return b ^ (IN_W'(1) << (r - RUN_W'(1)));
  endfunction

  function automatic logic [CNT_W-1:0] cnt_min(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Difference between the current core result and the stored baseline.
  assign xor_p0 = core_data_i ^ baseline_q;

  // Sweep sequencer: run bookkeeping, core handshake, result hand-off and statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      run_q        <= '0;
      base_q       <= '0;
      baseline_q   <= '0;
      wait_cnt     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      core_clr_o   <= 1'b0;
      core_start_o <= 1'b0;
      core_data_o  <= '0;
      res_valid_o  <= 1'b0;
      res_bit_o    <= '0;
      res_xor_o    <= '0;
      res_cnt_o    <= '0;
      sum_o        <= '0;
      min_o        <= CNT_INIT;
      max_o        <= '0;
    end else begin
      core_clr_o   <= 1'b0;
      core_start_o <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            base_q      <= base_i;
            run_q       <= '0;
            core_data_o <= base_i;
            core_clr_o  <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            sum_o       <= '0;
            min_o       <= CNT_INIT;
            max_o       <= '0;
            state       <= S_CLR;
          end
        end
        S_CLR: begin
          core_start_o <= 1'b1;
          state        <= S_LAUNCH;
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // The first WAIT cycle may still see ready left over from the previous run.
          if (wait_cnt != '0 && core_ready_i) begin
            state <= S_COUNT;
          end else if (wait_cnt == TMO_LAST) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            err_o  <= 1'b1;
            state  <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_COUNT: begin
          if (run_q == '0) begin
            baseline_q  <= core_data_i;
            run_q       <= RUN_W'(1);
            core_data_o <= run_word(base_q, RUN_W'(1));
            core_clr_o  <= 1'b1;
            state       <= S_CLR;
          end else begin
            res_xor_o   <= xor_p0;
            res_cnt_o   <= popcount(xor_p0);
            res_bit_o   <= BIT_W'(run_q - RUN_W'(1));
            res_valid_o <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            sum_o       <= sum_o + SUM_W'(res_cnt_o);
            min_o       <= cnt_min(min_o, res_cnt_o);
            max_o       <= cnt_max(max_o, res_cnt_o);
            if (run_q == RUN_LAST) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              run_q       <= run_q + RUN_W'(1);
              core_data_o <= run_word(base_q, run_q + RUN_W'(1));
              core_clr_o  <= 1'b1;
              state       <= S_CLR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
